timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
APB-style register front-end and sequencer for the 8-bit up/down timer counter. It holds the start value and control bits, and generates the counter's clk_ena from a programmable clock divider. It issues one-cycle load and flag-clear pulses and reports overflow/underflow status and an interrupt. It sits between the system bus and the counter instance; the counter's start_counter, up_down, enable, load, clk_ena, clr_overflow and clr_underflow inputs are driven only by this block.

Parameters:
ADDR_W, 8, APB address width; only the low 2 bits are decoded, and upper bits must be zero.
DIV_W, 4, divider counter width; cks selects a divide ratio of 2^(cks+1), giving 2/4/8/16.

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-low
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_W  register address
pwdata  in  8  write data
prdata  out  8  read data, valid while pready=1
pready  out  1  transfer complete
pslverr  out  1  error response, valid with pready
start_counter  out  8  TDR value to the counter
up_down  out  1  TCR[5]
enable  out  1  TCR[4]
load  out  1  one-cycle load pulse
clk_ena  out  1  one-cycle count-enable pulse
clr_overflow  out  1  one-cycle clear pulse
clr_underflow  out  1  one-cycle clear pulse
overflow  in  1  counter overflow flag
underflow  in  1  counter underflow flag
irq  out  1  registered interrupt

Behaviour:
- Reset (rst_n=0 at posedge) has the following effects:
  - All registers clear to 0 and the FSM goes to IDLE.
  - All outputs are 0, including prdata, pready, pslverr and irq.
  - Reset takes precedence over any in-flight transfer; that transfer is dropped with no register effect.
- Register map:
  - 0x00 TDR: R/W, 8 bits.
  - 0x01 TCR: R/W. Bit [7] load (write-only, reads 0), [5] up_down, [4] en, [3] ovie, [2] unie, [1:0] cks. Bit 6 reads 0.
  - 0x02 TSR: bit [0] overflow, bit [1] underflow, both reflecting the live inputs. Write-1-to-clear.
  - 0x03 and any address with nonzero upper bits: invalid.
- Bus FSM states: IDLE, SETUP, WAIT, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> WAIT when penable=1. There is exactly one wait state.
  - WAIT -> ACCESS unconditionally. pready=1 only in ACCESS, for one cycle.
  - ACCESS -> SETUP if psel=1 and penable=0 (back-to-back transfer); otherwise ACCESS -> IDLE.
  - psel dropping in SETUP or WAIT returns the FSM to IDLE with no effect.
- Write commit: registers update at the edge ending ACCESS.
  - Writing TCR with bit7=1 causes load=1 in the next cycle only. The other TCR fields commit on the same edge, so start_counter, up_down and enable are already valid when load is high.
  - Writing TSR with bit0=1 or bit1=1 causes the matching clr_overflow / clr_underflow to pulse for one cycle in the next cycle.
- Read: prdata is driven in ACCESS only and is 0 otherwise.
- Invalid address: pslverr=1 with pready, prdata=0, no register effect.
- Divider:
  - While en=0, div_cnt is held at 0 and clk_ena=0.
  - While en=1, div_cnt counts 0 .. 2^(cks+1)-1 and wraps.
  - clk_ena is registered: it is high for one cycle following the cycle in which div_cnt equals its terminal value.
  - A TCR write that changes cks or sets en from 0 to 1 restarts div_cnt at 0 on the commit edge. The first clk_ena then occurs exactly 2^(cks+1) cycles later, with no spurious or short pulse.
  - A TCR write that changes neither cks nor en does not disturb the divider phase.
- irq is registered: irq <= (overflow & ovie) | (underflow & unie), i.e. one cycle of latency from the flag.
- Simultaneous events:
  - A clear pulse in the same cycle as the counter setting a flag: the controller still issues the pulse; resolving the collision is the counter's responsibility.
  - Load in the same cycle as clk_ena: both pulses are issued.

Decomposition:
- Package timer_pkg holds:
  - address constants ADDR_TDR / ADDR_TCR / ADDR_TSR;
  - TCR bit-index constants;
  - the FSM state enum.
- One sub-module, timer_clk_div, contains div_cnt, terminal-value compare and clk_ena register. Its inputs are en, cks and a restart pulse.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles, then release -> all outputs 0, reading TCR returns 0x00.
- Load sequence: write TDR=0x0A, then write TCR=0x90 (load, en, down, cks=0) -> start_counter=0x0A, enable=1, up_down=0, load high for exactly 1 cycle after the commit, first clk_ena 2 cycles after the commit, period 2.
- Divider change: en=1 with cks=0, then write cks=3 -> div_cnt restarts, next clk_ena exactly 16 cycles after the commit, period 16, no extra pulse.
- Status and irq: set ovie=1, drive overflow=1 -> irq=1 one cycle later and TSR reads 0x01. Write TSR=0x01 -> clr_overflow pulses for 1 cycle; when overflow drops, irq drops one cycle later.
- Error and timing: read address 0x03 -> pslverr=1, prdata=0. Run back-to-back transfers -> each completes with exactly one wait state. Drop psel in WAIT -> pready never asserts and no register changes.
- Mid-transfer reset: assert rst_n=0 during WAIT of a TDR write -> TDR stays 0, FSM returns to IDLE, no load pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and types for the timer controller.
//   - register addresses (low 2 bits of paddr)
//   - TCR / TSR bit positions
//   - bus sequencer state encoding and the stored TCR fields
package timer_pkg;

  localparam logic [1:0] ADDR_TDR = 2'd0;
  localparam logic [1:0] ADDR_TCR = 2'd1;
  localparam logic [1:0] ADDR_TSR = 2'd2;

  localparam int TCR_LOAD = 7;
  localparam int TCR_UD   = 5;
  localparam int TCR_EN   = 4;
  localparam int TCR_OVIE = 3;
  localparam int TCR_UNIE = 2;
  localparam int TCR_CKS  = 0;   // 2-bit field [1:0]

  localparam int TSR_OVF  = 0;
  localparam int TSR_UNF  = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_ACCESS
  } apb_state_e;

  // Stored TCR fields; load is a strobe and is not kept.
  typedef struct packed {
    logic       up_down;
    logic       en;
    logic       ovie;
    logic       unie;
    logic [1:0] cks;
  } tcr_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// APB-style bus bundle for the timer controller.
//   master: drives psel/penable/pwrite/paddr/pwdata
//   slave : drives prdata/pready/pslverr
interface timer_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/timer_clk_div.sv
// Programmable count-enable generator.
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : divider runs while high, held at 0 otherwise
//   cks_i      : ratio select, period = 2^(cks_i+1) cycles
//   restart_i  : forces the counter back to 0 on this edge
//   clk_ena_o  : registered one-cycle pulse, the cycle after terminal count
module timer_clk_div #(
  parameter int DIV_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] cks_i,
  input  logic       restart_i,
  output logic       clk_ena_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d, term;
  logic             ena_q, ena_d;

  always_comb begin
    case (cks_i)
      2'd0:    term = DIV_W'(1);
      2'd1:    term = DIV_W'(3);
      2'd2:    term = DIV_W'(7);
      default: term = DIV_W'(15);
    endcase
  end

  // Restart also squashes a pulse that the old phase would have produced,
  // so the first pulse after a restart comes a full period later.
  always_comb begin
    cnt_d = '0;
    ena_d = 1'b0;
    if (en_i && !restart_i) begin
      ena_d = (cnt_q == term);
      cnt_d = ena_d ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ena_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ena_q <= ena_d;
    end
  end

  assign clk_ena_o = ena_q;

endmodule

// File: rtl/timer_ctrl.sv
// Register front-end and sequencer for the 8-bit up/down timer counter.
//   clk, rst_n      : clock, synchronous active-low reset
//   bus             : APB-style slave (one wait state, pready in ACCESS)
//   start_counter   : TDR contents
//   up_down, enable : TCR fields
//   load            : one-cycle pulse after a TCR write with bit 7 set
//   clk_ena         : divided count-enable pulse
//   clr_overflow/underflow : one-cycle pulses from TSR write-1-to-clear
//   overflow/underflow     : live counter flags
//   irq             : registered masked flag OR
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_ctrl_if.slave bus,
  output logic [7:0]  start_counter,
  output logic        up_down,
  output logic        enable,
  output logic        load,
  output logic        clk_ena,
  output logic        clr_overflow,
  output logic        clr_underflow,
  input  logic        overflow,
  input  logic        underflow,
  output logic        irq
);

  apb_state_e        state_q, state_d;
  logic [7:0]        tdr_q, tdr_d;
  tcr_t              tcr_q, tcr_d;
  logic              load_q, load_d;
  logic              clr_ovf_q, clr_ovf_d;
  logic              clr_unf_q, clr_unf_d;
  logic              irq_q, irq_d;
  logic              restart;
  logic              access, addr_ok, wr_commit;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        rdata;

  assign paddr     = bus.paddr;
  assign addr_ok   = ((paddr >> 2) == '0) && (paddr[1:0] != 2'd3);
  assign access    = (state_q == ST_ACCESS);
  assign wr_commit = access && bus.pwrite && addr_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.psel && !bus.penable) state_d = ST_SETUP;
      ST_SETUP:  if (!bus.psel)                state_d = ST_IDLE;
                 else if (bus.penable)         state_d = ST_WAIT;
      ST_WAIT:   state_d = bus.psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = (bus.psel && !bus.penable) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tdr_d     = tdr_q;
    tcr_d     = tcr_q;
    load_d    = 1'b0;
    clr_ovf_d = 1'b0;
    clr_unf_d = 1'b0;
    restart   = 1'b0;
    if (wr_commit) begin
      case (paddr[1:0])
        ADDR_TDR: tdr_d = bus.pwdata;
        ADDR_TCR: begin
          tcr_d.up_down = bus.pwdata[TCR_UD];
          tcr_d.en      = bus.pwdata[TCR_EN];
          tcr_d.ovie    = bus.pwdata[TCR_OVIE];
          tcr_d.unie    = bus.pwdata[TCR_UNIE];
          tcr_d.cks     = bus.pwdata[TCR_CKS +: 2];
          load_d        = bus.pwdata[TCR_LOAD];
          // Any change of ratio or of en re-phases the divider; a clear of
          // en also lands here so no stale pulse escapes after disable.
          restart = (tcr_d.cks != tcr_q.cks) || (tcr_d.en != tcr_q.en);
        end
        ADDR_TSR: begin
          clr_ovf_d = bus.pwdata[TSR_OVF];
          clr_unf_d = bus.pwdata[TSR_UNF];
        end
        default: ;
      endcase
    end
    irq_d = (overflow & tcr_q.ovie) | (underflow & tcr_q.unie);
  end

  always_comb begin
    rdata = '0;
    if (access && !bus.pwrite && addr_ok) begin
      case (paddr[1:0])
        ADDR_TDR: rdata = tdr_q;
        ADDR_TCR: begin
          rdata[TCR_UD]        = tcr_q.up_down;
          rdata[TCR_EN]        = tcr_q.en;
          rdata[TCR_OVIE]      = tcr_q.ovie;
          rdata[TCR_UNIE]      = tcr_q.unie;
          rdata[TCR_CKS +: 2]  = tcr_q.cks;
        end
        ADDR_TSR: begin
          rdata[TSR_OVF] = overflow;
          rdata[TSR_UNF] = underflow;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tdr_q     <= '0;
      tcr_q     <= '0;
      load_q    <= 1'b0;
      clr_ovf_q <= 1'b0;
      clr_unf_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tdr_q     <= tdr_d;
      tcr_q     <= tcr_d;
      load_q    <= load_d;
      clr_ovf_q <= clr_ovf_d;
      clr_unf_q <= clr_unf_d;
      irq_q     <= irq_d;
    end
  end

  timer_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (tcr_q.en),
    .cks_i     (tcr_q.cks),
    .restart_i (restart),
    .clk_ena_o (clk_ena)
  );

  assign bus.prdata    = rdata;
  assign bus.pready    = access;
  assign bus.pslverr   = access && !addr_ok;
  assign start_counter = tdr_q;
  assign up_down       = tcr_q.up_down;
  assign enable        = tcr_q.en;
  assign load          = load_q;
  assign clr_overflow  = clr_ovf_q;
  assign clr_underflow = clr_unf_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: bus responses go through a scoreboard queue checked
// by a monitor on the falling edge; sideband pulses are checked inline.
module tb_timer_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] start_counter;
  logic       up_down, enable, load, clk_ena;
  logic       clr_overflow, clr_underflow;
  logic       overflow, underflow, irq;

  timer_ctrl_if #(.ADDR_W(8)) bus ();

  timer_ctrl #(.ADDR_W(8), .DIV_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .start_counter (start_counter),
    .up_down       (up_down),
    .enable        (enable),
    .load          (load),
    .clk_ena       (clk_ena),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .overflow      (overflow),
    .underflow     (underflow),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       err;
    logic       chk_rd;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every completed transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.pready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pready got pready=1 exp no transfer");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.pslverr !== e.err || (e.chk_rd && bus.prdata !== e.rd)) begin
          errors++;
          $display("FAIL %s got rd=%0h err=%b exp rd=%0h err=%b",
                   e.nm, bus.prdata, bus.pslverr, e.rd, e.err);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transfer: FSM IDLE -> SETUP -> WAIT -> ACCESS, returns in the
  // cycle after the commit edge.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                     input logic [7:0] exp_rd, input logic exp_err, input string nm);
    exp_t e;
    e.rd = exp_rd; e.err = exp_err; e.chk_rd = !wr; e.nm = nm;
    sbq.push_back(e);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = data;
    tick;
    bus.penable = 1'b1;
    tick;
    check("wait_state_pready", {31'd0, bus.pready}, 32'd0);
    tick;
    tick;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  // Samples n cycles starting with the current one (k=1).
  task automatic observe(input int n, output int first, output int last,
                         output int cnt, output int lcnt);
    first = 0; last = 0; cnt = 0; lcnt = 0;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) tick;
      if (clk_ena) begin
        if (first == 0) first = k;
        last = k;
        cnt++;
      end
      if (load) lcnt++;
    end
  endtask

  int f, l, c, lc;

  initial begin
    rst_n = 1'b0; overflow = 1'b0; underflow = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    // Reset state
    repeat (5) tick;
    check("rst_outputs",
          {start_counter, up_down, enable, load, clk_ena, clr_overflow,
           clr_underflow, irq, bus.pready, bus.pslverr, bus.prdata}, 32'd0);
    rst_n = 1'b1;
    tick;
    apb(1'b0, 8'h01, 8'h00, 8'h00, 1'b0, "rd_tcr_after_reset");

    // Load sequence: TDR=0x0A, TCR=0x90 (load, en, down, cks=0)
    apb(1'b1, 8'h00, 8'h0A, 8'h00, 1'b0, "wr_tdr");
    apb(1'b1, 8'h01, 8'h90, 8'h00, 1'b0, "wr_tcr_load");
    check("start_counter", {24'd0, start_counter}, 32'h0A);
    check("enable", {31'd0, enable}, 32'd1);
    check("up_down", {31'd0, up_down}, 32'd0);
    check("load_pulse", {31'd0, load}, 32'd1);
    observe(5, f, l, c, lc);
    check("div2_first", f, 3);
    check("div2_last", l, 5);
    check("div2_count", c, 2);
    check("load_one_cycle", lc, 1);

    // Divider change to cks=3: period 16 from the commit edge
    apb(1'b1, 8'h01, 8'h13, 8'h00, 1'b0, "wr_tcr_cks3");
    observe(33, f, l, c, lc);
    check("div16_first", f, 17);
    check("div16_last", l, 33);
    check("div16_count", c, 2);
    check("no_load_cks3", lc, 0);

    // Phase kept: TCR write changing only ovie; current cycle holds a pulse,
    // the next one is 16 cycles on, i.e. k=13 after the 4-cycle transfer.
    apb(1'b1, 8'h01, 8'h1B, 8'h00, 1'b0, "wr_tcr_ovie");
    observe(16, f, l, c, lc);
    check("phase_kept_first", f, 13);
    check("phase_kept_count", c, 1);
    apb(1'b0, 8'h01, 8'h00, 8'h1B, 1'b0, "rd_tcr");

    // Status and irq
    overflow = 1'b1;
    check("irq_before", {31'd0, irq}, 32'd0);
    tick;
    check("irq_set", {31'd0, irq}, 32'd1);
    apb(1'b0, 8'h02, 8'h00, 8'h01, 1'b0, "rd_tsr_ovf");
    apb(1'b1, 8'h02, 8'h01, 8'h00, 1'b0, "wr_tsr_clr");
    check("clr_ovf_pulse", {30'd0, clr_overflow, clr_underflow}, 32'h2);
    tick;
    check("clr_ovf_end", {30'd0, clr_overflow, clr_underflow}, 32'h0);
    overflow = 1'b0;
    check("irq_hold", {31'd0, irq}, 32'd1);
    tick;
    check("irq_drop", {31'd0, irq}, 32'd0);
    underflow = 1'b1;
    tick;
    tick;
    check("irq_unie_masked", {31'd0, irq}, 32'd0);
    apb(1'b0, 8'h02, 8'h00, 8'h02, 1'b0, "rd_tsr_unf");
    underflow = 1'b0;

    // Errors, back to back
    apb(1'b0, 8'h03, 8'h00, 8'h00, 1'b1, "rd_addr3");
    apb(1'b0, 8'h84, 8'h00, 8'h00, 1'b1, "rd_upper");
    apb(1'b1, 8'h04, 8'hFF, 8'h00, 1'b1, "wr_upper");
    apb(1'b0, 8'h00, 8'h00, 8'h0A, 1'b0, "rd_tdr_unchanged");

    // psel dropped in WAIT
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h00; bus.pwdata = 8'h55;
    tick;
    bus.penable = 1'b1;
    tick;
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (4) tick;
    apb(1'b0, 8'h00, 8'h00, 8'h0A, 1'b0, "rd_tdr_after_abort");

    // Reset during WAIT of a TDR write
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'h00; bus.pwdata = 8'h77;
    tick;
    bus.penable = 1'b1;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    check("midrst_load", {31'd0, load}, 32'd0);
    check("midrst_pready", {31'd0, bus.pready}, 32'd0);
    repeat (2) tick;
    apb(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "rd_tdr_after_rst");
    apb(1'b0, 8'h01, 8'h00, 8'h00, 1'b0, "rd_tcr_after_rst");

    repeat (3) tick;
    check("scoreboard_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
